// File: rtl/fbuf_pkg.sv
// Shared framebuffer definitions: geometry defaults, RGB332 colours and the
// arbiter state encoding.
package fbuf_pkg;

  localparam int DEF_FRAME_WIDTH     = 640;
  localparam int DEF_FRAME_HEIGHT    = 480;
  localparam int DEF_SCALING_FACTOR  = 1;
  localparam int DEF_FBUF_ADDR_WIDTH = 19;
  localparam int DEF_FBUF_DATA_WIDTH = 8;

  localparam logic [7:0] COLOR_RED   = 8'hE0;
  localparam logic [7:0] COLOR_BLUE  = 8'h03;
  localparam logic [7:0] COLOR_BLACK = 8'h00;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } fbuf_state_e;

  function automatic int frame_pixels(input int width, input int height, input int scale);
    return (width / scale) * (height / scale);
  endfunction

endpackage

// File: rtl/fbuf_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request searching upward
// from last_grant+1, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         grant_idx,
  output logic               grant_valid
);

  logic [3:0] req_pad;
  logic [1:0] idx;

  always_comb begin
    req_pad = '0;
    req_pad[NUM_REQ-1:0] = req;
    idx = '0;
    grant_idx = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 2'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_valid && req_pad[idx]) begin
        grant_idx = idx;
        grant_valid = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = grant_valid && (grant_idx == 2'(i));
    end
  end

endmodule

// File: rtl/fbuf_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin pixel writers plus a full-frame
// fill engine that owns the port while clearing.
//
//   state    | meaning
//   ST_ARB   | round-robin over requesters, one accepted write per cycle
//   ST_CLEAR | fill engine writes 0..FRAME_PIXELS-1, requesters stalled
module fbuf_write_arbiter
  import fbuf_pkg::*;
#(
  parameter int FRAME_WIDTH     = DEF_FRAME_WIDTH,
  parameter int FRAME_HEIGHT    = DEF_FRAME_HEIGHT,
  parameter int SCALING_FACTOR  = DEF_SCALING_FACTOR,
  parameter int FBUF_ADDR_WIDTH = DEF_FBUF_ADDR_WIDTH,
  parameter int FBUF_DATA_WIDTH = DEF_FBUF_DATA_WIDTH,
  parameter int NUM_REQ         = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*FBUF_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*FBUF_DATA_WIDTH-1:0]   req_color,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic                                 clear_start,
  input  logic [FBUF_DATA_WIDTH-1:0]           clear_color,
  output logic                                 clear_busy,
  output logic                                 clear_done,
  output logic [FBUF_ADDR_WIDTH-1:0]           fbuf_address,
  output logic [FBUF_DATA_WIDTH-1:0]           fbuf_color,
  output logic                                 fbuf_wr_en,
  output logic [1:0]                           grant_id
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || FBUF_DATA_WIDTH != 8) begin : g_bad_params
    $error("fbuf_write_arbiter: NUM_REQ must be 2..4 and FBUF_DATA_WIDTH must be 8");
  end

  localparam int FRAME_PIXELS = frame_pixels(FRAME_WIDTH, FRAME_HEIGHT, SCALING_FACTOR);
  localparam logic [FBUF_ADDR_WIDTH-1:0] LAST_ADDR = FBUF_ADDR_WIDTH'(FRAME_PIXELS - 1);
  localparam logic [FBUF_ADDR_WIDTH:0]   PIX_LIMIT = (FBUF_ADDR_WIDTH + 1)'(FRAME_PIXELS);

  fbuf_state_e                state, state_nxt;
  logic [1:0]                 last_grant, last_grant_nxt;
  logic [FBUF_ADDR_WIDTH-1:0] clear_addr, clear_addr_nxt;
  logic [FBUF_DATA_WIDTH-1:0] clear_color_q, clear_color_nxt;
  logic [FBUF_ADDR_WIDTH-1:0] addr_nxt;
  logic [FBUF_DATA_WIDTH-1:0] color_nxt;
  logic                       wr_en_nxt, busy_nxt, done_nxt;
  logic [1:0]                 grant_id_nxt;

  logic [NUM_REQ-1:0]         arb_grant;
  logic [1:0]                 arb_idx;
  logic                       arb_valid;
  logic [FBUF_ADDR_WIDTH-1:0] sel_addr;
  logic [FBUF_DATA_WIDTH-1:0] sel_color;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req         (req_valid),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == 2'(i)) begin
        sel_addr  = req_addr[i*FBUF_ADDR_WIDTH +: FBUF_ADDR_WIDTH];
        sel_color = req_color[i*FBUF_DATA_WIDTH +: FBUF_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_ARB;
      last_grant    <= 2'(NUM_REQ - 1);
      clear_addr    <= '0;
      clear_color_q <= '0;
      fbuf_address  <= '0;
      fbuf_color    <= '0;
      fbuf_wr_en    <= 1'b0;
      grant_id      <= '0;
      clear_busy    <= 1'b0;
      clear_done    <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_grant    <= last_grant_nxt;
      clear_addr    <= clear_addr_nxt;
      clear_color_q <= clear_color_nxt;
      fbuf_address  <= addr_nxt;
      fbuf_color    <= color_nxt;
      fbuf_wr_en    <= wr_en_nxt;
      grant_id      <= grant_id_nxt;
      clear_busy    <= busy_nxt;
      clear_done    <= done_nxt;
    end
  end

  // Port registers always carry the write for the following cycle, so the
  // first fill word is presented in the first ST_CLEAR cycle.
  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    clear_addr_nxt  = clear_addr;
    clear_color_nxt = clear_color_q;
    addr_nxt        = fbuf_address;
    color_nxt       = fbuf_color;
    wr_en_nxt       = 1'b0;
    grant_id_nxt    = '0;
    busy_nxt        = 1'b0;
    done_nxt        = 1'b0;
    req_ready       = '0;

    case (state)
      ST_ARB: begin
        if (clear_start) begin
          state_nxt       = ST_CLEAR;
          clear_color_nxt = clear_color;
          clear_addr_nxt  = '0;
          addr_nxt        = '0;
          color_nxt       = clear_color;
          wr_en_nxt       = 1'b1;
          busy_nxt        = 1'b1;
          done_nxt        = (LAST_ADDR == '0);
        end else if (arb_valid && rst_n) begin
          req_ready      = arb_grant;
          last_grant_nxt = arb_idx;
          // Out-of-frame writes are consumed silently; the port holds.
          if ({1'b0, sel_addr} < PIX_LIMIT) begin
            addr_nxt     = sel_addr;
            color_nxt    = sel_color;
            wr_en_nxt    = 1'b1;
            grant_id_nxt = arb_idx;
          end
        end
      end
      ST_CLEAR: begin
        if (clear_addr == LAST_ADDR) begin
          state_nxt = ST_ARB;
        end else begin
          clear_addr_nxt = clear_addr + 1'b1;
          addr_nxt       = clear_addr + 1'b1;
          color_nxt      = clear_color_q;
          wr_en_nxt      = 1'b1;
          busy_nxt       = 1'b1;
          done_nxt       = ((clear_addr + 1'b1) == LAST_ADDR);
        end
      end
      default: state_nxt = ST_ARB;
    endcase
  end

endmodule
